// File: rtl/mem_write_ctrl.sv
// -----------------------------------------------------------------------------
// mem_write_ctrl
//
// Purpose:
//   Button-driven write controller for a small memory with a per-entry valid
//   bit. A rising edge on the debounced `enter` level captures addr/din and,
//   two cycles later, commits the data into the memory while driving one
//   enable line of an external valid-bit register bank. A `clear_all`
//   request sweeps every valid bit to 0, one entry per cycle. An internal
//   shadow copy of the valid bits drives the overwrite pulse, the
//   valid-entry count and the masked read port.
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset
//   enter      in   debounced write button (level); only its rising edge acts
//   clear_all  in   level request to invalidate every entry
//   addr       in   write address
//   din        in   write data
//   rd_addr    in   read address
//   valid_we   out  one-hot enables for the external valid-bit registers
//   valid_d    out  data value for the enabled valid-bit register
//   data_out   out  registered read data (0 for an invalid entry)
//   data_valid out  registered valid flag of the rd_addr entry
//   busy       out  high whenever the FSM is not IDLE
//   ovw        out  one-cycle pulse when a commit overwrites a valid entry
//   count      out  number of currently valid entries, 0..8
//   state_dbg  out  current FSM state encoding, for observation only
//
// Handshake:
//   There is no valid/ready pair on this block. A write request is the
//   rising edge of `enter` seen while IDLE; any edge or clear request seen
//   while busy is dropped, never queued. clear_all wins over a simultaneous
//   edge.
// -----------------------------------------------------------------------------
module mem_write_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter,
  input  logic             clear_all,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       rd_addr,
  output logic [DEPTH-1:0] valid_we,
  output logic             valid_d,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             ovw,
  output logic [3:0]       count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2,
    CLEAR   = 2'd3
  } state_t;

  localparam logic [DEPTH-1:0] ONE_HOT_0 = {{(DEPTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]       LAST_IDX  = 3'd7;

  state_t           state_q, state_d;
  logic             enter_q;
  logic             enter_rise;
  logic [2:0]       addr_q, addr_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [2:0]       idx_q, idx_d;
  logic [DEPTH-1:0] shadow_q, shadow_d;
  logic [3:0]       count_q, count_d;
  logic             mem_we;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] data_out_q;
  logic             data_valid_q;

  // enter_q resets high so a button held through reset release is not
  // mistaken for a fresh press.
  assign enter_rise = enter & ~enter_q;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    din_d    = din_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    valid_we = '0;
    valid_d  = 1'b0;
    ovw      = 1'b0;
    mem_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clear_all) begin
          state_d = CLEAR;
          idx_d   = 3'd0;
        end else if (enter_rise) begin
          state_d = CAPTURE;
          addr_d  = addr;
          din_d   = din;
        end
      end

      CAPTURE: begin
        state_d = COMMIT;
      end

      COMMIT: begin
        valid_we = ONE_HOT_0 << addr_q;
        valid_d  = 1'b1;
        mem_we   = 1'b1;
        ovw      = shadow_q[addr_q];
        // count tracks the shadow population, so it can only grow when the
        // target was empty and therefore never exceeds DEPTH.
        if (!shadow_q[addr_q]) begin
          count_d = count_q + 4'd1;
        end
        shadow_d[addr_q] = 1'b1;
        state_d          = IDLE;
      end

      CLEAR: begin
        valid_we        = ONE_HOT_0 << idx_q;
        shadow_d[idx_q] = 1'b0;
        if (shadow_q[idx_q]) begin
          count_d = count_q - 4'd1;
        end
        idx_d = idx_q + 3'd1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          count_d = 4'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A reset cycle aborts whatever operation is in flight: nothing reaches
    // the external valid bank or the memory in that cycle.
    if (reset) begin
      valid_we = '0;
      valid_d  = 1'b0;
      ovw      = 1'b0;
      mem_we   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      enter_q  <= 1'b1;
      addr_q   <= 3'd0;
      din_q    <= '0;
      idx_q    <= 3'd0;
      shadow_q <= '0;
      count_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      enter_q  <= enter;
      addr_q   <= addr_d;
      din_q    <= din_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array: never reset, invalid entries are masked on read instead.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= din_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: one-cycle registered read of the current array contents, no
  // bypass of a commit happening in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= shadow_q[rd_addr] ? mem_q[rd_addr] : '0;
      data_valid_q <= shadow_q[rd_addr];
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = (state_q != IDLE);
  assign count      = count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mem_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_write_ctrl
//
// Directed bench for mem_write_ctrl. A reference model (model_mem,
// model_valid, model_count) is updated as writes and clears are issued;
// read expectations are pushed into a queue when a read is driven and
// popped when the registered read data appears.
// -----------------------------------------------------------------------------
module tb_mem_write_ctrl;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             enter;
  logic             clear_all;
  logic [2:0]       addr;
  logic [WIDTH-1:0] din;
  logic [2:0]       rd_addr;
  logic [DEPTH-1:0] valid_we;
  logic             valid_d;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic             ovw;
  logic [3:0]       count;
  logic [1:0]       state_dbg;

  mem_write_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enter      (enter),
    .clear_all  (clear_all),
    .addr       (addr),
    .din        (din),
    .rd_addr    (rd_addr),
    .valid_we   (valid_we),
    .valid_d    (valid_d),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .ovw        (ovw),
    .count      (count),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] model_mem   [DEPTH];
  logic             model_valid [DEPTH];
  int               model_count;
  logic [WIDTH-1:0] exp_q  [$];
  logic             expv_q [$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;
    model_count = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Issue a write from IDLE with enter low in the previous cycle.
  task automatic do_write(input logic [2:0] a, input logic [WIDTH-1:0] d);
    logic exp_ovw;
    exp_ovw = model_valid[a];
    enter = 1'b1; addr = a; din = d;
    tick();                                   // CAPTURE
    enter = 1'b0;
    chk("cap_busy", 32'(busy), 1);
    chk("cap_we", 32'(valid_we), 0);
    tick();                                   // COMMIT
    chk("commit_we", 32'(valid_we), 32'(8'h01 << a));
    chk("commit_vd", 32'(valid_d), 1);
    chk("commit_ovw", 32'(ovw), 32'(exp_ovw));
    tick();                                   // back in IDLE
    if (!model_valid[a]) model_count++;
    model_valid[a] = 1'b1;
    model_mem[a]   = d;
    chk("post_count", 32'(count), 32'(model_count));
    chk("post_ovw", 32'(ovw), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_vd", 32'(valid_d), 0);
  endtask

  task automatic read_check(input logic [2:0] a);
    logic [WIDTH-1:0] e;
    logic             ev;
    rd_addr = a;
    exp_q.push_back(model_valid[a] ? model_mem[a] : 8'h00);
    expv_q.push_back(model_valid[a]);
    tick();
    e  = exp_q.pop_front();
    ev = expv_q.pop_front();
    chk($sformatf("rd_data[%0d]", a), 32'(data_out), 32'(e));
    chk($sformatf("rd_valid[%0d]", a), 32'(data_valid), 32'(ev));
  endtask

  // Walk a full sweep starting in the CLEAR cycle for index 0.
  task automatic check_sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      chk({tag, "_we"}, 32'(valid_we), 32'(8'h01 << i));
      chk({tag, "_vd"}, 32'(valid_d), 0);
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; enter = 1'b0; clear_all = 1'b0;
    addr = 3'd0; din = '0; rd_addr = 3'd0;
    model_clear();
    tick(); tick();

    // Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(valid_we), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_dvalid", 32'(data_valid), 0);
    chk("rst_ovw", 32'(ovw), 0);
    reset = 1'b0;
    tick();

    // First write, then overwrite of the same entry
    do_write(3'd3, 8'hA5);
    read_check(3'd3);
    do_write(3'd3, 8'h5A);
    read_check(3'd3);
    chk("ovw_count", 32'(count), 1);

    // Second edge while busy is dropped
    enter = 1'b1; addr = 3'd1; din = 8'h11;
    tick();                                   // CAPTURE
    enter = 1'b0;
    tick();                                   // COMMIT
    enter = 1'b1; addr = 3'd2; din = 8'h22;   // edge during COMMIT
    chk("dbl_we", 32'(valid_we), 32'h02);
    tick();                                   // IDLE, enter still high
    model_valid[1] = 1'b1; model_mem[1] = 8'h11; model_count++;
    chk("dbl_count", 32'(count), 32'(model_count));
    tick();
    chk("dbl_busy", 32'(busy), 0);
    enter = 1'b0;
    tick();
    read_check(3'd2);
    read_check(3'd1);

    // Fill every entry with random data
    for (int i = 0; i < DEPTH; i++) begin
      do_write(3'(i), 8'($urandom_range(0, 255)));
    end
    chk("fill_count", 32'(count), 8);
    for (int i = 0; i < DEPTH; i++) read_check(3'(i));

    // Single-cycle clear_all pulse
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    check_sweep("clr");
    model_clear();
    chk("clr_busy", 32'(busy), 0);
    chk("clr_count", 32'(count), 0);
    chk("clr_we_idle", 32'(valid_we), 0);
    for (int i = 0; i < DEPTH; i++) read_check(3'(i));

    // clear_all held together with an enter edge: clear wins, sweeps repeat
    do_write(3'd4, 8'h44);
    enter = 1'b1; clear_all = 1'b1; addr = 3'd7; din = 8'h77;
    tick();
    check_sweep("hold");
    chk("hold_gap_busy", 32'(busy), 0);
    chk("hold_gap_we", 32'(valid_we), 0);
    tick();
    chk("hold_2nd_busy", 32'(busy), 1);
    chk("hold_2nd_we", 32'(valid_we), 32'h01);
    clear_all = 1'b0; enter = 1'b0;
    repeat (DEPTH) tick();
    model_clear();
    chk("hold_busy", 32'(busy), 0);
    chk("hold_count", 32'(count), 0);
    read_check(3'd7);
    read_check(3'd4);

    // enter held high through reset release
    do_write(3'd6, 8'h66);
    reset = 1'b1; enter = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_clear();
    tick();
    chk("rel_busy0", 32'(busy), 0);
    chk("rel_we0", 32'(valid_we), 0);
    tick();
    chk("rel_busy1", 32'(busy), 0);
    chk("rel_count", 32'(count), 0);
    enter = 1'b0;
    tick();
    read_check(3'd6);

    // Reset asserted during CAPTURE aborts the write
    enter = 1'b1; addr = 3'd5; din = 8'h55;
    tick();                                   // CAPTURE
    chk("abort_cap_busy", 32'(busy), 1);
    reset = 1'b1; enter = 1'b0;
    chk("abort_rst_we", 32'(valid_we), 0);
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_we", 32'(valid_we), 0);
    tick();
    chk("abort_we2", 32'(valid_we), 0);
    chk("abort_count", 32'(count), 0);
    read_check(3'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
